// File: rtl/aim65_bus_pkg.sv
// ============================================================================
//  Module      : aim65_bus_pkg
//  Description : Shared types and constants for the AIM-65 bus decoder:
//                wait-state FSM state encoding, region index width and the
//                default AIM-65 memory map (base / mask / wait states /
//                read-only flags), laid out as flat vectors that can feed the
//                decoder's region_* ports directly.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aim65_bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_WAIT  = 2'd1,
        BUS_GRANT = 2'd2
    } bus_state_t;

    localparam int AIM65_NUM_REGIONS = 12;
    localparam int AIM65_ADDR_W      = 16;
    localparam int AIM65_WS_W        = 3;
    localparam int REGION_IDX_W      = $clog2(AIM65_NUM_REGIONS);

    // Region indices of the default map. Lower index wins on overlap.
    localparam int RGN_RAM_LO = 0;   // 0000-3FFF
    localparam int RGN_RAM_HI = 1;   // 4000-7FFF
    localparam int RGN_VIDEO  = 2;   // 9000-9FFF
    localparam int RGN_Z22    = 3;   // F000-FFFF ROM
    localparam int RGN_Z23    = 4;   // E000-EFFF ROM
    localparam int RGN_Z24    = 5;   // D000-DFFF ROM
    localparam int RGN_Z25    = 6;   // C000-CFFF ROM
    localparam int RGN_Z26    = 7;   // B000-BFFF ROM
    localparam int RGN_A0     = 8;   // A000-A3FF user VIA
    localparam int RGN_A4     = 9;   // A400-A7FF RIOT
    localparam int RGN_A8     = 10;  // A800-ABFF system VIA
    localparam int RGN_AC     = 11;  // AC00-AFFF PIA

    // Flat vectors, region i at [i*W +: W] (index 0 is the rightmost field).
    localparam logic [AIM65_NUM_REGIONS*AIM65_ADDR_W-1:0] AIM65_MAP_BASE = {
        16'hAC00, 16'hA800, 16'hA400, 16'hA000,
        16'hB000, 16'hC000, 16'hD000, 16'hE000,
        16'hF000, 16'h9000, 16'h4000, 16'h0000
    };

    localparam logic [AIM65_NUM_REGIONS*AIM65_ADDR_W-1:0] AIM65_MAP_MASK = {
        16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00,
        16'hF000, 16'hF000, 16'hF000, 16'hF000,
        16'hF000, 16'hF000, 16'hC000, 16'hC000
    };

    localparam logic [AIM65_NUM_REGIONS*AIM65_WS_W-1:0] AIM65_MAP_WS = '0;

    // ROM sockets Z22..Z26 are read-only.
    localparam logic [AIM65_NUM_REGIONS-1:0] AIM65_MAP_RO = 12'b0000_1111_1000;

endpackage

`default_nettype wire

// File: rtl/aim65_region_match.sv
// ============================================================================
//  Module      : aim65_region_match
//  Description : Base/mask window compare for NUM_REGIONS regions followed by
//                a lowest-index-wins priority encoder. Purely combinational.
//  Ports       : addr_i        - CPU address
//                region_base_i - flat base addresses, region i at [i*ADDR_W]
//                region_mask_i - flat compare masks (1 = bit compared)
//                cs_o          - one-hot (or zero) chip-select
//                hit_idx_o     - index of the winning region (0 on miss)
//                hit_o         - any region matched
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aim65_region_match #(
    parameter int NUM_REGIONS = 12,
    parameter int ADDR_W      = 16,
    parameter int IDX_W       = 4
) (
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask_i,
    output logic [NUM_REGIONS-1:0]        cs_o,
    output logic [IDX_W-1:0]              hit_idx_o,
    output logic                          hit_o
);

    logic [NUM_REGIONS-1:0] w_raw_hit;

    // XOR form is equivalent to (addr & mask) == (base & mask).
    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_cmp
        assign w_raw_hit[i] =
            ((addr_i ^ region_base_i[i*ADDR_W +: ADDR_W]) &
              region_mask_i[i*ADDR_W +: ADDR_W]) == '0;
    end

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        cs_o      = '0;
        hit_idx_o = '0;
        hit_o     = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_raw_hit[i]) begin
                cs_o      = '0;
                cs_o[i]   = 1'b1;
                hit_idx_o = IDX_W'(i);
                hit_o     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aim65_bus_decoder.sv
// ============================================================================
//  Module      : aim65_bus_decoder
//  Description : AIM-65 CPU bus address decoder. Drives one-hot chip-selects
//                from NUM_REGIONS base/mask windows, stretches RDY by a
//                per-region wait-state count, gates write strobes (never into
//                read-only regions) and registers the read-data select so
//                cpu_din follows the 6502 one-cycle read latency.
//  Ports       : cpu_clk, reset (sync, active-high)
//                addr, rw (1 = read)           - CPU bus
//                region_base/mask/ws/ro         - quasi-static region table
//                dev_do                         - per-region read data
//                cs, we                         - per-region select / strobe
//                rdy, cpu_din                   - to CPU RDY / DI
//                ro_violation                   - pulse after a ROM write
//  Options     : AIM65_BUS_FAULT_EN adds fault_valid / fault_addr / fault_clr,
//                a sticky latch of the first unmapped access or ROM write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aim65_bus_decoder
    import aim65_bus_pkg::*;
#(
    parameter int                NUM_REGIONS   = 12,
    parameter int                ADDR_W        = 16,
    parameter int                DATA_W        = 8,
    parameter int                WS_W          = 3,
    parameter logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF
) (
    input  logic                          cpu_clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          rw,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
    input  logic [NUM_REGIONS*WS_W-1:0]   region_ws,
    input  logic [NUM_REGIONS-1:0]        region_ro,
    input  logic [NUM_REGIONS*DATA_W-1:0] dev_do,
`ifdef AIM65_BUS_FAULT_EN
    output logic                          fault_valid,
    output logic [ADDR_W-1:0]             fault_addr,
    input  logic                          fault_clr,
`endif
    output logic [NUM_REGIONS-1:0]        cs,
    output logic [NUM_REGIONS-1:0]        we,
    output logic                          rdy,
    output logic [DATA_W-1:0]             cpu_din,
    output logic                          ro_violation
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] w_cs;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_hit;

    aim65_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_match (
        .addr_i        (addr),
        .region_base_i (region_base),
        .region_mask_i (region_mask),
        .cs_o          (w_cs),
        .hit_idx_o     (w_hit_idx),
        .hit_o         (w_hit)
    );

    logic [WS_W-1:0]   w_ws  [NUM_REGIONS];
    logic [DATA_W-1:0] w_dev [NUM_REGIONS];

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_unpack
        assign w_ws[i]  = region_ws[i*WS_W +: WS_W];
        assign w_dev[i] = dev_do[i*DATA_W +: DATA_W];
    end

    logic [WS_W-1:0] w_hit_ws;
    assign w_hit_ws = w_hit ? w_ws[w_hit_idx] : '0;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    bus_state_t       state_q, state_d;
    logic [WS_W-1:0]  cnt_q, cnt_d;
    logic             sel_valid_q;
    logic [IDX_W-1:0] sel_idx_q;
    logic             ro_violation_q;
    logic             w_rdy;
    logic             w_write_ro;

    // rdy must drop in the same cycle the address appears, so it is decoded
    // combinationally from the current state and the live hit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_rdy   = 1'b1;
        case (state_q)
            BUS_IDLE: begin
                if (w_hit_ws != '0) begin
                    w_rdy   = 1'b0;
                    cnt_d   = w_hit_ws - WS_W'(1);
                    state_d = (w_hit_ws == WS_W'(1)) ? BUS_GRANT : BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                // Only cnt_q is consulted here: a region_ws change mid-stall
                // does not disturb the access in flight.
                w_rdy = 1'b0;
                cnt_d = cnt_q - WS_W'(1);
                if (cnt_q == WS_W'(1)) begin
                    state_d = BUS_GRANT;
                end
            end
            BUS_GRANT: begin
                // Always back to IDLE so a repeat access to the same region
                // pays its wait states again.
                w_rdy   = 1'b1;
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
        if (reset) begin
            w_rdy = 1'b1;
        end
    end

    assign w_write_ro = ~reset & w_rdy & ~rw & (|(w_cs & region_ro));

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q        <= BUS_IDLE;
            cnt_q          <= '0;
            sel_valid_q    <= 1'b0;
            sel_idx_q      <= '0;
            ro_violation_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ro_violation_q <= w_write_ro;
            // Capture only on the completing cycle; hold during the stall.
            if (w_rdy) begin
                sel_valid_q <= w_hit;
                sel_idx_q   <= w_hit_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cs           = w_cs;
    assign we           = w_cs & ~region_ro & {NUM_REGIONS{~rw & w_rdy & ~reset}};
    assign rdy          = w_rdy;
    assign cpu_din      = sel_valid_q ? w_dev[sel_idx_q] : UNMAPPED_DATA;
    assign ro_violation = ro_violation_q;

`ifdef AIM65_BUS_FAULT_EN
    // ------------------------------------------------------------------
    // Sticky fault latch: first unmapped access or ROM write wins until
    // cleared; a fault coincident with the clear is latched.
    // ------------------------------------------------------------------
    logic              fault_valid_q;
    logic [ADDR_W-1:0] fault_addr_q;
    logic              w_fault;

    assign w_fault = w_rdy & (~w_hit | w_write_ro);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (w_fault && (fault_clr || !fault_valid_q)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= addr;
        end else if (fault_clr) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign fault_valid = fault_valid_q;
    assign fault_addr  = fault_addr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aim65_bus_decoder.sv
// ============================================================================
//  Module      : tb_aim65_bus_decoder
//  Description : Self-checking bench for aim65_bus_decoder. A local region
//                table and reference decode predict cs / rdy / we per cycle;
//                each completing cycle pushes the expected next-cycle
//                cpu_din / ro_violation onto a scoreboard queue that is
//                popped and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aim65_bus_decoder;

    localparam int NR = 12;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WW = 3;

    logic             cpu_clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    addr;
    logic             rw;
    logic [NR*AW-1:0] region_base;
    logic [NR*AW-1:0] region_mask;
    logic [NR*WW-1:0] region_ws;
    logic [NR-1:0]    region_ro;
    logic [NR*DW-1:0] dev_do;
    logic [NR-1:0]    cs;
    logic [NR-1:0]    we;
    logic             rdy;
    logic [DW-1:0]    cpu_din;
    logic             ro_violation;
`ifdef AIM65_BUS_FAULT_EN
    logic             fault_valid;
    logic [AW-1:0]    fault_addr;
    logic             fault_clr;
`endif

    aim65_bus_decoder #(
        .NUM_REGIONS   (NR),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .WS_W          (WW),
        .UNMAPPED_DATA (8'hFF)
    ) dut (
        .cpu_clk      (cpu_clk),
        .reset        (reset),
        .addr         (addr),
        .rw           (rw),
        .region_base  (region_base),
        .region_mask  (region_mask),
        .region_ws    (region_ws),
        .region_ro    (region_ro),
        .dev_do       (dev_do),
`ifdef AIM65_BUS_FAULT_EN
        .fault_valid  (fault_valid),
        .fault_addr   (fault_addr),
        .fault_clr    (fault_clr),
`endif
        .cs           (cs),
        .we           (we),
        .rdy          (rdy),
        .cpu_din      (cpu_din),
        .ro_violation (ro_violation)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Bench-side region table
    logic [AW-1:0] base_cfg [NR];
    logic [AW-1:0] mask_cfg [NR];
    logic [WW-1:0] ws_cfg   [NR];
    logic          ro_cfg   [NR];
    logic [DW-1:0] dev_cfg  [NR];

    typedef struct packed {
        logic [DW-1:0] din;
        logic          rov;
    } sb_t;

    sb_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic load_default();
        base_cfg = '{16'h0000, 16'h4000, 16'h9000, 16'hF000, 16'hE000, 16'hD000,
                     16'hC000, 16'hB000, 16'hA000, 16'hA400, 16'hA800, 16'hAC00};
        mask_cfg = '{16'hC000, 16'hC000, 16'hF000, 16'hF000, 16'hF000, 16'hF000,
                     16'hF000, 16'hF000, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        ro_cfg   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < NR; i++) begin
            ws_cfg[i]  = '0;
            dev_cfg[i] = 8'h30 + 8'(i);
        end
        dev_cfg[3] = 8'hA9;  // Z22
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NR; i++) begin
            region_base[i*AW +: AW] = base_cfg[i];
            region_mask[i*AW +: AW] = mask_cfg[i];
            region_ws[i*WW +: WW]   = ws_cfg[i];
            region_ro[i]            = ro_cfg[i];
            dev_do[i*DW +: DW]      = dev_cfg[i];
        end
    endtask

    function automatic int ref_idx(input logic [AW-1:0] a);
        for (int i = 0; i < NR; i++) begin
            if ((a & mask_cfg[i]) == (base_cfg[i] & mask_cfg[i])) return i;
        end
        return -1;
    endfunction

    // Compare registered outputs against whatever the previous completing
    // cycle promised.
    task automatic drain();
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("cpu_din", cpu_din, e.din);
            check_val("ro_violation", ro_violation, e.rov);
        end else begin
            check_val("ro_violation_quiet", ro_violation, 0);
        end
    endtask

    // One CPU access starting at posedge+1; returns at posedge+1 after the
    // completing cycle.
    task automatic access(input logic [AW-1:0] a, input logic r);
        int          idx;
        int          n;
        logic [NR-1:0] oh;
        logic [NR-1:0] exp_we;
        sb_t         e;
        idx = ref_idx(a);
        n   = (idx >= 0) ? int'(ws_cfg[idx]) : 0;
        oh  = '0;
        if (idx >= 0) oh[idx] = 1'b1;
        exp_we = (idx >= 0 && !r && !ro_cfg[idx]) ? oh : '0;
        addr = a;
        rw   = r;
        for (int c = 0; c <= n; c++) begin
            @(negedge cpu_clk);
            drain();
            check_val("cs", cs, oh);
            if (c < n) begin
                check_val("rdy_stall", rdy, 0);
                check_val("we_stall", we, 0);
            end else begin
                check_val("rdy_done", rdy, 1);
                check_val("we_done", we, exp_we);
                e.din = (idx >= 0) ? dev_cfg[idx] : 8'hFF;
                e.rov = (idx >= 0) && !r && ro_cfg[idx];
                sb_q.push_back(e);
            end
            @(posedge cpu_clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_default();
        apply_cfg();
        reset = 1'b1;
        addr  = 16'h8800;
        rw    = 1'b1;
`ifdef AIM65_BUS_FAULT_EN
        fault_clr = 1'b0;
`endif
        repeat (3) @(posedge cpu_clk);
        #1;

        // Reset state
        @(negedge cpu_clk);
        check_val("reset_rdy", rdy, 1);
        check_val("reset_we", we, 0);
        check_val("reset_din", cpu_din, 8'hFF);
        check_val("reset_rov", ro_violation, 0);
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;

        // Zero wait-state reads / writes across the map
        access(16'hF000, 1'b1);
        access(16'h8800, 1'b1);
        access(16'h0000, 1'b1);
        access(16'h4321, 1'b1);
        access(16'hA400, 1'b0);
        access(16'hE123, 1'b1);

        // Video with 3 wait states
        ws_cfg[2] = 3'd3;
        apply_cfg();
        access(16'h9000, 1'b1);
        access(16'h8800, 1'b1);

        // Write into a 2 wait-state region
        ws_cfg[2] = 3'd2;
        apply_cfg();
        access(16'h9010, 1'b0);
        access(16'h8800, 1'b1);

        // Single wait state, back-to-back to the same region
        ws_cfg[8] = 3'd1;
        apply_cfg();
        access(16'hA000, 1'b1);
        access(16'hA001, 1'b0);

        // Write to ROM
`ifdef AIM65_BUS_FAULT_EN
        fault_clr = 1'b1;
`endif
        access(16'hD000, 1'b0);
`ifdef AIM65_BUS_FAULT_EN
        fault_clr = 1'b0;
        check_val("fault_valid", fault_valid, 1);
        check_val("fault_addr", fault_addr, 16'hD000);
`endif
        access(16'h8800, 1'b1);
        access(16'h8800, 1'b1);

        // Overlap: region 3 moved on top of region 0
        base_cfg[3] = 16'h0000;
        mask_cfg[3] = 16'hC000;
        apply_cfg();
        access(16'h0123, 1'b1);
        load_default();
        apply_cfg();
        access(16'h8800, 1'b1);

        // Reset in the 2nd cycle of a 5 wait-state write
        ws_cfg[2] = 3'd5;
        apply_cfg();
        addr = 16'h9000;
        rw   = 1'b0;
        @(negedge cpu_clk);
        drain();
        check_val("rst_mid_rdy_first", rdy, 0);
        @(posedge cpu_clk);
        #1;
        reset = 1'b1;
        @(negedge cpu_clk);
        check_val("rst_mid_we", we, 0);
        check_val("rst_mid_rdy", rdy, 1);
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        addr  = 16'h8800;
        rw    = 1'b1;
        @(negedge cpu_clk);
        check_val("rst_after_rdy", rdy, 1);
        check_val("rst_after_we", we, 0);
        check_val("rst_after_din", cpu_din, 8'hFF);
        check_val("rst_after_rov", ro_violation, 0);
        @(posedge cpu_clk);
        #1;
        ws_cfg[2] = 3'd0;
        apply_cfg();
        access(16'h8800, 1'b1);

        @(negedge cpu_clk);
        drain();
        check_val("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
